// File: rtl/comm_uart_tx.sv
// Inter-board link transmitter: packs one game message into a 5-byte frame
// (header, 3 payload bytes, XOR checksum) and shifts it out as 8N1 on UART_TXD.
module comm_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       send_new_message,
    input  logic       ball_message_tx,
    input  logic [8:0] ball_y_tx,
    input  logic [3:0] velocity_x_tx,
    input  logic [3:0] velocity_y_tx,
    input  logic       miss_message_tx,
    input  logic [4:0] my_score_tx,
    input  logic [4:0] your_score_tx,
    input  logic       you_should_serve_tx,
    input  logic       new_game_message_tx,
    input  logic       you_serve_first_tx,
    input  logic       new_game_ack_message_tx,
    output logic       message_sent,
    output logic       busy,
    output logic       msg_error,
    output logic       UART_TXD
);

    localparam int unsigned BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W     = $clog2(8);
    localparam int unsigned BYTE_W    = $clog2(5);
    localparam int unsigned FRAME_W   = 40;
    localparam int unsigned PAYLOAD_W = 24;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(7);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(4);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [BYTE_W-1:0]    byte_q, byte_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 sent_q, sent_d;
    logic                 err_q, err_d;

    logic [3:0]           flags;
    logic                 type_valid;
    logic [1:0]           type_code;
    logic [PAYLOAD_W-1:0] payload;
    logic [7:0]           header;
    logic [7:0]           checksum;
    logic [FRAME_W-1:0]   frame_new;
    logic [7:0]           cur_byte;
    logic [BIT_W-1:0]     bit_nxt;
    logic                 baud_done;

    assign flags = {new_game_ack_message_tx, new_game_message_tx,
                    miss_message_tx, ball_message_tx};

    // Frame assembly from the live inputs; only captured at the accept edge.
    always_comb begin
        type_valid = 1'b1;
        type_code  = 2'b00;
        case (flags)
            4'b0001: type_code = 2'b00;
            4'b0010: type_code = 2'b01;
            4'b0100: type_code = 2'b10;
            4'b1000: type_code = 2'b11;
            default: type_valid = 1'b0;
        endcase

        case (type_code)
            2'b00:   payload = {7'b0, ball_y_tx, velocity_x_tx, velocity_y_tx};
            2'b01:   payload = {13'b0, my_score_tx, your_score_tx, you_should_serve_tx};
            2'b10:   payload = {23'b0, you_serve_first_tx};
            default: payload = 24'b0;
        endcase

        header    = {4'b1010, type_code, 2'b00};
        checksum  = header ^ payload[23:16] ^ payload[15:8] ^ payload[7:0];
        frame_new = {header, payload, checksum};
    end

    // Byte currently on the line, header first.
    always_comb begin
        case (byte_q)
            BYTE_W'(0): cur_byte = frame_q[39:32];
            BYTE_W'(1): cur_byte = frame_q[31:24];
            BYTE_W'(2): cur_byte = frame_q[23:16];
            BYTE_W'(3): cur_byte = frame_q[15:8];
            default:    cur_byte = frame_q[7:0];
        endcase
    end

    assign bit_nxt   = bit_q + BIT_W'(1);
    assign baud_done = (baud_q == BAUD_LAST);

    // Next-state and next-output logic; the register below holds every output.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        sent_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (send_new_message) begin
                    if (type_valid) begin
                        frame_d = frame_new;
                        state_d = START;
                        baud_d  = '0;
                        bit_d   = '0;
                        byte_d  = '0;
                        txd_d   = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    txd_d   = cur_byte[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        txd_d = cur_byte[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_q == BYTE_LAST) begin
                        state_d = DONE;
                        sent_d  = 1'b1;
                        busy_d  = 1'b0;
                        txd_d   = 1'b1;
                    end else begin
                        byte_d  = byte_q + BYTE_W'(1);
                        state_d = START;
                        txd_d   = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end

            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset drives the line idle at once; a frame in flight is simply dropped.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            frame_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            sent_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            frame_q <= frame_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
        end
    end

    assign UART_TXD     = txd_q;
    assign busy         = busy_q;
    assign message_sent = sent_q;
    assign msg_error    = err_q;

endmodule

// File: tb/tb_comm_uart_tx.sv
// Scoreboard bench for comm_uart_tx: stimulus queues expected bytes and pulse
// times, a negedge monitor decodes the serial line and checks against them.
module tb_comm_uart_tx;

    localparam int unsigned CPB       = 4;
    localparam int unsigned FRAME_CYC = 50 * CPB;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       send_new_message = 1'b0;
    logic       ball_message_tx = 1'b0;
    logic [8:0] ball_y_tx = '0;
    logic [3:0] velocity_x_tx = '0;
    logic [3:0] velocity_y_tx = '0;
    logic       miss_message_tx = 1'b0;
    logic [4:0] my_score_tx = '0;
    logic [4:0] your_score_tx = '0;
    logic       you_should_serve_tx = 1'b0;
    logic       new_game_message_tx = 1'b0;
    logic       you_serve_first_tx = 1'b0;
    logic       new_game_ack_message_tx = 1'b0;
    logic       message_sent;
    logic       busy;
    logic       msg_error;
    logic       UART_TXD;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc    = 0;

    logic [7:0] exp_bytes[$];
    int         exp_sent[$];
    int         exp_err[$];

    comm_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .send_new_message        (send_new_message),
        .ball_message_tx         (ball_message_tx),
        .ball_y_tx               (ball_y_tx),
        .velocity_x_tx           (velocity_x_tx),
        .velocity_y_tx           (velocity_y_tx),
        .miss_message_tx         (miss_message_tx),
        .my_score_tx             (my_score_tx),
        .your_score_tx           (your_score_tx),
        .you_should_serve_tx     (you_should_serve_tx),
        .new_game_message_tx     (new_game_message_tx),
        .you_serve_first_tx      (you_serve_first_tx),
        .new_game_ack_message_tx (new_game_ack_message_tx),
        .message_sent            (message_sent),
        .busy                    (busy),
        .msg_error               (msg_error),
        .UART_TXD                (UART_TXD)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serial decoder and pulse checker, sampling on the falling edge.
    initial begin : monitor
        logic       rx_active;
        int         rx_t;
        int         j;
        logic [7:0] rx_data;
        logic       prev_busy;
        int         e;
        rx_active = 1'b0;
        rx_t      = 0;
        rx_data   = '0;
        prev_busy = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (reset) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (UART_TXD === 1'b0) begin
                    rx_active = 1'b1;
                    rx_t      = 0;
                end
            end else begin
                rx_t++;
                if ((rx_t % CPB) == (CPB / 2)) begin
                    j = rx_t / CPB;
                    if (j >= 1 && j <= 8) begin
                        rx_data[3'(j - 1)] = UART_TXD;
                    end else if (j == 9) begin
                        rx_active = 1'b0;
                        check("stop_bit", 32'(UART_TXD), 32'd1);
                        if (exp_bytes.size() == 0) begin
                            check("unexpected_byte", 32'(rx_data), 32'hFFFF_FFFF);
                        end else begin
                            check("rx_byte", 32'(rx_data), 32'(exp_bytes.pop_front()));
                        end
                    end
                end
            end

            if (message_sent === 1'b1) begin
                if (exp_sent.size() == 0) begin
                    check("unexpected_message_sent", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    e = exp_sent.pop_front();
                    check("message_sent_cycle", 32'(cyc), 32'(e));
                    check("busy_drops_with_sent", 32'(busy), 32'd0);
                    check("busy_high_before_sent", 32'(prev_busy), 32'd1);
                end
            end

            if (msg_error === 1'b1) begin
                if (exp_err.size() == 0) begin
                    check("unexpected_msg_error", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    check("msg_error_cycle", 32'(cyc), 32'(exp_err.pop_front()));
                end
            end
            prev_busy = busy;
        end
    end

    task automatic set_fields(input logic [3:0] flags, input logic [8:0] y,
                              input logic [3:0] vx, input logic [3:0] vy,
                              input logic [4:0] my, input logic [4:0] your,
                              input logic srv, input logic sf);
        {new_game_ack_message_tx, new_game_message_tx,
         miss_message_tx, ball_message_tx} = flags;
        ball_y_tx           = y;
        velocity_x_tx       = vx;
        velocity_y_tx       = vy;
        my_score_tx         = my;
        your_score_tx       = your;
        you_should_serve_tx = srv;
        you_serve_first_tx  = sf;
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic [7:0] b4, input int accept_cyc);
        exp_bytes.push_back(b0);
        exp_bytes.push_back(b1);
        exp_bytes.push_back(b2);
        exp_bytes.push_back(b3);
        exp_bytes.push_back(b4);
        exp_sent.push_back(accept_cyc + int'(FRAME_CYC));
    endtask

    task automatic pulse_send();
        send_new_message = 1'b1;
        @(negedge CLOCK_50);
        send_new_message = 1'b0;
    endtask

    // Returns on the first idle cycle after message_sent.
    task automatic wait_sent();
        int n;
        n = 0;
        while (message_sent !== 1'b1 && n < int'(FRAME_CYC) + 50) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (message_sent !== 1'b1) check("wait_sent_timeout", 32'(n), 32'hFFFF_FFFF);
        @(negedge CLOCK_50);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        repeat (3) @(negedge CLOCK_50);
        check("reset_txd", 32'(UART_TXD), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sent", 32'(message_sent), 32'd0);
        check("reset_err", 32'(msg_error), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);

        // Ball handoff
        set_fields(4'b0001, 9'd300, 4'd3, 4'hE, 5'd0, 5'd0, 1'b0, 1'b0);
        acc = cyc + 1;
        push_frame(8'hA0, 8'h01, 8'h2C, 8'h3E, 8'hB3, acc);
        pulse_send();
        check("busy_after_accept", 32'(busy), 32'd1);
        check("start_bit_after_accept", 32'(UART_TXD), 32'd0);
        wait_sent();

        // Miss
        set_fields(4'b0010, 9'd0, 4'd0, 4'd0, 5'd5, 5'd3, 1'b1, 1'b0);
        acc = cyc + 1;
        push_frame(8'hA4, 8'h00, 8'h01, 8'h47, 8'hE2, acc);
        pulse_send();
        wait_sent();

        // New game
        set_fields(4'b0100, 9'd0, 4'd0, 4'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        acc = cyc + 1;
        push_frame(8'hA8, 8'h00, 8'h00, 8'h01, 8'hA9, acc);
        pulse_send();
        wait_sent();

        // New-game ack
        set_fields(4'b1000, 9'd0, 4'd0, 4'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        acc = cyc + 1;
        push_frame(8'hAC, 8'h00, 8'h00, 8'h00, 8'hAC, acc);
        pulse_send();
        wait_sent();

        // Illegal: two flags, then none
        set_fields(4'b0011, 9'd300, 4'd3, 4'hE, 5'd5, 5'd3, 1'b1, 1'b0);
        acc = cyc + 1;
        exp_err.push_back(acc);
        pulse_send();
        for (int i = 0; i < 3; i++) begin
            check("illegal2_txd_idle", 32'(UART_TXD), 32'd1);
            check("illegal2_not_busy", 32'(busy), 32'd0);
            @(negedge CLOCK_50);
        end
        set_fields(4'b0000, 9'd0, 4'd0, 4'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        acc = cyc + 1;
        exp_err.push_back(acc);
        pulse_send();
        for (int i = 0; i < 3; i++) begin
            check("illegal0_txd_idle", 32'(UART_TXD), 32'd1);
            check("illegal0_not_busy", 32'(busy), 32'd0);
            @(negedge CLOCK_50);
        end

        // Busy collision during byte 2, then back-to-back send after message_sent
        set_fields(4'b0010, 9'd0, 4'd0, 4'd0, 5'd5, 5'd3, 1'b1, 1'b0);
        acc = cyc + 1;
        push_frame(8'hA4, 8'h00, 8'h01, 8'h47, 8'hE2, acc);
        pulse_send();
        while (cyc < acc + 85) @(negedge CLOCK_50);
        set_fields(4'b0001, 9'd511, 4'd15, 4'd7, 5'd31, 5'd31, 1'b0, 1'b1);
        pulse_send();
        wait_sent();
        set_fields(4'b1000, 9'd0, 4'd0, 4'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        acc = cyc + 1;
        push_frame(8'hAC, 8'h00, 8'h00, 8'h00, 8'hAC, acc);
        pulse_send();
        wait_sent();

        // Input stability: fields churn every cycle after accept
        set_fields(4'b0001, 9'd300, 4'd3, 4'hE, 5'd0, 5'd0, 1'b0, 1'b0);
        acc = cyc + 1;
        push_frame(8'hA0, 8'h01, 8'h2C, 8'h3E, 8'hB3, acc);
        pulse_send();
        begin
            int n;
            n = 0;
            while (message_sent !== 1'b1 && n < int'(FRAME_CYC) + 50) begin
                set_fields(4'($urandom), 9'($urandom), 4'($urandom), 4'($urandom),
                           5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
                @(negedge CLOCK_50);
                n++;
            end
            if (message_sent !== 1'b1) check("stability_timeout", 32'(n), 32'hFFFF_FFFF);
            set_fields(4'b0000, 9'd0, 4'd0, 4'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            @(negedge CLOCK_50);
        end

        // Reset during data bit 3 of byte 1
        set_fields(4'b0001, 9'd300, 4'd3, 4'hE, 5'd0, 5'd0, 1'b0, 1'b0);
        acc = cyc + 1;
        push_frame(8'hA0, 8'h01, 8'h2C, 8'h3E, 8'hB3, acc);
        pulse_send();
        while (cyc < acc + 10 * int'(CPB) + 4 * int'(CPB) + 1) @(negedge CLOCK_50);
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_mid_txd", 32'(UART_TXD), 32'd1);
        check("reset_mid_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge CLOCK_50);
        exp_bytes.delete();
        exp_sent.delete();
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("post_reset_txd", 32'(UART_TXD), 32'd1);
        check("post_reset_busy", 32'(busy), 32'd0);
        set_fields(4'b1000, 9'd0, 4'd0, 4'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        acc = cyc + 1;
        push_frame(8'hAC, 8'h00, 8'h00, 8'h00, 8'hAC, acc);
        pulse_send();
        wait_sent();

        repeat (10) @(negedge CLOCK_50);
        check("bytes_outstanding", 32'(exp_bytes.size()), 32'd0);
        check("sent_outstanding", 32'(exp_sent.size()), 32'd0);
        check("err_outstanding", 32'(exp_err.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/comm_uart_tx.md
Name: comm_uart_tx

Overview:
Serializes one game message (ball handoff, miss/score, new-game, new-game ack) into a fixed 5-byte frame and transmits it on the UART TX pin as 8N1. It sits downstream of the game state logic, which drives the message fields and the send request, and directly drives UART_TXD. It replaces the CommunicationSender stub as the transmit half of the inter-board link.

Parameters:
CLKS_PER_BIT, 434, CLOCK_50 cycles per UART bit (115200 baud at 50 MHz); legal range 2 to 1023.

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high
send_new_message  in  1  request; sampled only in IDLE
ball_message_tx  in  1  message type flag: ball handoff
ball_y_tx  in  9  ball row entering the opponent side
velocity_x_tx  in  4  unsigned x speed
velocity_y_tx  in  4  signed y velocity, positive is down
miss_message_tx  in  1  message type flag: miss
my_score_tx  in  5  sender's score
your_score_tx  in  5  receiver's score
you_should_serve_tx  in  1  receiver serves next
new_game_message_tx  in  1  message type flag: new game
you_serve_first_tx  in  1  receiver serves first
new_game_ack_message_tx  in  1  message type flag: new-game ack
message_sent  out  1  one-cycle pulse when the last stop bit completes
busy  out  1  high from accept until message_sent
msg_error  out  1  one-cycle pulse when a request is rejected
UART_TXD  out  1  serial line, idle high

Behaviour:
- Reset values: UART_TXD=1, busy=0, message_sent=0, msg_error=0, state IDLE, all counters 0. Reset asserted mid-frame forces UART_TXD high immediately, with no partial stop bit. The frame is abandoned and no message_sent is issued.
- Accept: the request is accepted on a rising edge in IDLE with send_new_message=1 and exactly one type flag high. At that edge all fields are latched into a 40-bit frame register and busy rises. Later input changes have no effect on the frame in flight.
- Reject: send_new_message=1 in IDLE with zero or more than one type flag high. The block pulses msg_error for one cycle, stays IDLE and sends nothing.
- send_new_message while busy is ignored. It is not queued and does not raise msg_error.
- Type code: ball=00, miss=01, new game=10, ack=11.
- Header byte = {4'b1010, type[1:0], 2'b00}.
- 24-bit payload P by type:
  - ball: {7'b0, ball_y, velocity_x, velocity_y}
  - miss: {13'b0, my_score, your_score, you_should_serve}
  - new game: {23'b0, you_serve_first}
  - ack: 24'b0
- Byte order on the line: header, P[23:16], P[15:8], P[7:0], checksum.
- Checksum = XOR of the four preceding bytes.
- Each byte is sent 8N1, LSB first: one start bit (0), 8 data bits, one stop bit (1). Every bit lasts exactly CLKS_PER_BIT cycles. There is no gap between bytes.
- FSM states: IDLE -> START -> DATA (8 bits) -> STOP -> either START for the next byte (byte index 0..4) or DONE after byte 4. DONE pulses message_sent and clears busy in the same cycle, then returns to IDLE.
- A new request can be accepted on the cycle after DONE.
- UART_TXD is registered. The start bit begins on the cycle after accept.
- Total frame time = 50*CLKS_PER_BIT cycles from the first TXD low to the end of the last stop bit. message_sent pulses on the following cycle.
- The bit counter and byte index are sized by $clog2 of their range. The baud counter must not wrap mid-bit.

Test Plan:
- Ball, CLKS_PER_BIT=4: ball_y=300, vx=3, vy=4'hE, send pulsed 1 cycle -> bytes A0,01,2C,3E,B3 LSB first. Each bit lasts 4 cycles. Frame is 200 cycles. message_sent pulses once and busy drops with it.
- Miss: my=5, your=3, serve=1 -> bytes A4,00,01,47,E2. New game with serve_first=1 -> A8,00,00,01,A9. Ack -> AC,00,00,00,AC.
- Illegal type: ball and miss flags both high with send, or no flags with send -> one msg_error pulse, TXD stays high, busy stays 0.
- Busy collision: second send with different fields at byte 2 -> original frame completes unchanged, no second frame, no msg_error. A send on the cycle after message_sent is accepted.
- Input stability: fields toggled every cycle after accept -> transmitted bytes match the values latched at accept.
- Reset mid-frame: reset asserted during data bit 3 of byte 1 -> TXD=1 immediately, no message_sent. After release, a new ack request transmits a clean AC,00,00,00,AC.
